// File: rtl/pipeline_pkg.sv
// Shared width helpers and defaults for the pipeline datapath blocks.
package pipeline_pkg;

    localparam int DEFAULT_DATA_WIDTH = 32;

    // Floor of one address bit so a degenerate depth still produces a legal vector.
    function automatic int addr_width(input int depth);
        return (depth <= 2) ? 1 : $clog2(depth);
    endfunction

    function automatic int ptr_width(input int depth);
        return addr_width(depth) + 1;
    endfunction

endpackage

// File: rtl/pipeline_fifo_mem.sv
// DEPTH x DATA_WIDTH flop array: one write port, one combinational read port, no reset.
module pipeline_fifo_mem
    import pipeline_pkg::*;
#(
    parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
    parameter int DEPTH      = 8,
    parameter int AW         = addr_width(DEPTH)
) (
    input  logic                  clk,
    input  logic                  we,
    input  logic [AW-1:0]         waddr,
    input  logic [DATA_WIDTH-1:0] wdata,
    input  logic [AW-1:0]         raddr,
    output logic [DATA_WIDTH-1:0] rdata
);

    logic [DATA_WIDTH-1:0] r_mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            r_mem[waddr] <= wdata;
        end
    end

    assign rdata = r_mem[raddr];

endmodule

// File: rtl/pipeline_sync_fifo.sv
// First-word fall-through valid/ready FIFO with wrap-bit pointers and registered almost_full.
module pipeline_sync_fifo
    import pipeline_pkg::*;
#(
    parameter int DATA_WIDTH   = DEFAULT_DATA_WIDTH,
    parameter int DEPTH        = 8,
    parameter int AFULL_THRESH = 6
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [DATA_WIDTH-1:0]   u_data,
    input  logic                    u_valid,
    output logic                    u_ready,
    output logic [DATA_WIDTH-1:0]   d_data,
    output logic                    d_valid,
    input  logic                    d_ready,
    output logic [$clog2(DEPTH):0]  count,
    output logic                    almost_full
);

    localparam int AW = addr_width(DEPTH);
    localparam int PW = ptr_width(DEPTH);

    logic          r_en;
    logic [PW-1:0] r_wr_ptr;
    logic [PW-1:0] r_rd_ptr;
    logic          r_afull;

    logic          w_empty;
    logic          w_full;
    logic          w_push;
    logic          w_pop;
    logic [PW-1:0] w_wr_nxt;
    logic [PW-1:0] w_rd_nxt;
    logic [PW-1:0] w_count_nxt;

    assign w_empty = (r_wr_ptr == r_rd_ptr);
    assign w_full  = (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]) &&
                     (r_wr_ptr[AW] != r_rd_ptr[AW]);

    // Ready is a pure function of flops, so no comb path from d_ready or u_valid.
    assign u_ready = r_en && !w_full;
    assign d_valid = !w_empty;

    assign w_push = u_valid && u_ready;
    assign w_pop  = d_valid && d_ready;

    assign w_wr_nxt    = r_wr_ptr + PW'(w_push);
    assign w_rd_nxt    = r_rd_ptr + PW'(w_pop);
    assign w_count_nxt = w_wr_nxt - w_rd_nxt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_en     <= 1'b0;
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_afull  <= 1'b0;
        end else begin
            r_en     <= 1'b1;
            r_wr_ptr <= w_wr_nxt;
            r_rd_ptr <= w_rd_nxt;
            r_afull  <= (w_count_nxt >= PW'(AFULL_THRESH));
        end
    end

    assign count       = r_wr_ptr - r_rd_ptr;
    assign almost_full = r_afull;

    pipeline_fifo_mem #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (DEPTH),
        .AW         (AW)
    ) u_mem (
        .clk   (clk),
        .we    (w_push),
        .waddr (r_wr_ptr[AW-1:0]),
        .wdata (u_data),
        .raddr (r_rd_ptr[AW-1:0]),
        .rdata (d_data)
    );

endmodule

// File: tb/tb_pipeline_sync_fifo.sv
// Directed bench for pipeline_sync_fifo with a queue scoreboard checked by a negedge monitor.
module tb_pipeline_sync_fifo;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] u_data;
    logic        u_valid;
    logic        u_ready;
    logic [31:0] d_data;
    logic        d_valid;
    logic        d_ready;
    logic [3:0]  count;
    logic        almost_full;

    int          n_checks = 0;
    int          n_fail   = 0;
    int          pops_seen;
    logic [31:0] exp_q [$];

    always #5 clk = ~clk;

    pipeline_sync_fifo #(
        .DATA_WIDTH   (32),
        .DEPTH        (8),
        .AFULL_THRESH (6)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .u_data      (u_data),
        .u_valid     (u_valid),
        .u_ready     (u_ready),
        .d_data      (d_data),
        .d_valid     (d_valid),
        .d_ready     (d_ready),
        .count       (count),
        .almost_full (almost_full)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic fail_now(input string name, input int act, input int exp);
        n_checks++;
        n_fail++;
        $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    // Outputs are sampled on the falling edge; a handshake seen here completes on the next rising edge.
    task automatic monitor();
        logic        prev_hold = 1'b0;
        logic [31:0] prev_data = '0;
        logic [31:0] e;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                prev_hold = 1'b0;
            end else begin
                if (prev_hold) begin
                    chk("hold_valid", 64'(d_valid), 64'(1));
                    chk("hold_data", 64'(d_data), 64'(prev_data));
                end
                if (d_valid) chk("data_known", 64'($isunknown(d_data)), 64'(0));
                if (d_valid && d_ready) begin
                    if (exp_q.size() == 0) begin
                        fail_now("pop_unexpected", 1, 0);
                    end else begin
                        e = exp_q.pop_front();
                        chk("pop_data", 64'(d_data), 64'(e));
                    end
                    pops_seen++;
                end
                if (u_valid && u_ready) exp_q.push_back(u_data);
                prev_hold = d_valid && !d_ready;
                prev_data = d_data;
            end
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n     = 1'b0;
        u_valid   = 1'b1;
        u_data    = 32'hdead;
        d_ready   = 1'b0;
        pops_seen = 0;
        fork
            monitor();
        join_none

        // 1: start-up with u_valid held
        repeat (3) @(posedge clk);
        #1;
        chk("rst_u_ready", 64'(u_ready), 64'(0));
        chk("rst_d_valid", 64'(d_valid), 64'(0));
        chk("rst_count", 64'(count), 64'(0));
        chk("rst_afull", 64'(almost_full), 64'(0));
        rst_n = 1'b1;
        #1;
        chk("cycle0_u_ready", 64'(u_ready), 64'(0));
        @(posedge clk);
        #1;
        chk("en_u_ready", 64'(u_ready), 64'(1));
        chk("en_count", 64'(count), 64'(0));
        chk("en_d_valid", 64'(d_valid), 64'(0));
        u_valid = 1'b0;

        // 2: fill to full with downstream stalled
        for (int i = 0; i < 8; i++) begin
            u_valid = 1'b1;
            u_data  = 32'(i);
            @(posedge clk);
            #1;
            chk("fill_count", 64'(count), 64'(i + 1));
            chk("fill_afull", 64'(almost_full), 64'((i + 1) >= 6));
            chk("fill_u_ready", 64'(u_ready), 64'((i + 1) < 8));
            chk("fill_head", 64'(d_data), 64'(0));
        end
        u_data = 32'd8;
        repeat (2) begin
            @(posedge clk);
            #1;
            chk("full_count", 64'(count), 64'(8));
            chk("full_u_ready", 64'(u_ready), 64'(0));
            chk("full_head", 64'(d_data), 64'(0));
        end
        u_valid = 1'b0;

        // 3: drain from full
        d_ready = 1'b1;
        for (int k = 0; k < 8; k++) begin
            @(posedge clk);
            #1;
            chk("drain_count", 64'(count), 64'(7 - k));
            chk("drain_afull", 64'(almost_full), 64'((7 - k) >= 6));
            if (k < 7) chk("drain_head", 64'(d_data), 64'(k + 1));
        end
        chk("drain_d_valid", 64'(d_valid), 64'(0));
        chk("drain_q_empty", 64'(exp_q.size()), 64'(0));
        d_ready = 1'b0;

        // 4: push and pop together on the single occupied entry
        u_valid = 1'b1;
        u_data  = 32'd5;
        @(posedge clk);
        #1;
        chk("one_count", 64'(count), 64'(1));
        chk("one_head", 64'(d_data), 64'(5));
        u_data  = 32'd6;
        d_ready = 1'b1;
        @(posedge clk);
        #1;
        u_valid = 1'b0;
        d_ready = 1'b0;
        chk("swap_count", 64'(count), 64'(1));
        chk("swap_head", 64'(d_data), 64'(6));
        chk("swap_d_valid", 64'(d_valid), 64'(1));
        d_ready = 1'b1;
        @(posedge clk);
        #1;
        d_ready = 1'b0;
        chk("swap_drain_count", 64'(count), 64'(0));
        chk("swap_drain_d_valid", 64'(d_valid), 64'(0));

        // 5: random bubbles and stalls, 100 words
        pops_seen = 0;
        fork
            begin : producer
                int guard;
                bit acc;
                for (int w = 0; w < 100; w++) begin
                    repeat ($urandom_range(0, 3)) begin
                        u_valid = 1'b0;
                        @(posedge clk);
                        #1;
                    end
                    u_valid = 1'b1;
                    u_data  = 32'(w);
                    guard   = 0;
                    do begin
                        acc = u_ready;
                        @(posedge clk);
                        #1;
                        guard++;
                    end while (!acc && guard < 200);
                    if (!acc) fail_now("push_timeout", w, 0);
                end
                u_valid = 1'b0;
            end
            begin : consumer
                int cyc;
                int stall;
                cyc = 0;
                while (pops_seen < 100 && cyc < 3000) begin
                    stall = $urandom_range(0, 3);
                    d_ready = 1'b0;
                    repeat (stall) begin
                        @(posedge clk);
                        #1;
                        cyc++;
                    end
                    d_ready = 1'b1;
                    @(posedge clk);
                    #1;
                    cyc++;
                end
                d_ready = 1'b0;
                if (pops_seen < 100) fail_now("pop_timeout", pops_seen, 100);
            end
        join
        chk("stream_pops", 64'(pops_seen), 64'(100));
        chk("stream_q_empty", 64'(exp_q.size()), 64'(0));

        // 6: asynchronous reset with data stored
        d_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            u_valid = 1'b1;
            u_data  = 32'(10 + i);
            @(posedge clk);
            #1;
        end
        u_valid = 1'b0;
        chk("pre_rst_count", 64'(count), 64'(4));
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        exp_q.delete();
        #1;
        chk("async_d_valid", 64'(d_valid), 64'(0));
        chk("async_count", 64'(count), 64'(0));
        chk("async_u_ready", 64'(u_ready), 64'(0));
        chk("async_afull", 64'(almost_full), 64'(0));
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk("post_rst_u_ready", 64'(u_ready), 64'(1));
        u_valid = 1'b1;
        u_data  = 32'd42;
        @(posedge clk);
        #1;
        u_data = 32'd43;
        @(posedge clk);
        #1;
        u_valid = 1'b0;
        chk("post_rst_count", 64'(count), 64'(2));
        chk("post_rst_head", 64'(d_data), 64'(42));
        d_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        d_ready = 1'b0;
        chk("post_rst_drain", 64'(count), 64'(0));
        chk("post_rst_q_empty", 64'(exp_q.size()), 64'(0));

        repeat (2) @(posedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
